// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the sequencing one-hot decoder.
//   - mode encodings presented on the decoder's mode input
//   - controller state type
//   - onehot(): index -> one-hot vector, sized for the widest supported decoder
package decoder_pkg;

    // Widest select supported by onehot(); callers size-cast the result down.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    localparam logic [1:0] MODE_DIRECT    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_ONESHOT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_SHOT   = 2'd3
    } state_t;

    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned index);
        logic [MAX_OUT_W-1:0] v;
        v = {{(MAX_OUT_W-1){1'b0}}, 1'b1} << index;
        return v;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts cycles spent on the current index.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (takes priority over run)
//   run        : advance the count; on expiry the count returns to zero
//   dwell      : live compare value (hold time is dwell+1 cycles)
//   expired    : count has reached (or passed) dwell
// With neither clr nor run the count holds, which is how the decoder freezes
// sequencing while disabled.
module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt;

    // >= rather than == so that lowering dwell below the running count
    // still expires on the next compare instead of counting round.
    assign expired = (cnt >= dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= expired ? '0 : cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with automatic sequencing.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable; low blanks out and freezes all sequencing state
//   mode       : DIRECT / SCAN_UP / SCAN_DOWN / ONESHOT
//   sel        : decode value (DIRECT) or start index (scan / sweep)
//   load       : single-cycle (re)start strobe for scan / sweep
//   dwell      : each index is held dwell+1 cycles
//   out        : registered one-hot of idx, or all-zero
//   idx        : current index
//   busy       : high while a one-shot sweep is running
//   wrap       : one-cycle pulse on scan wrap-around or sweep end
// SEL_W must not exceed decoder_pkg::MAX_SEL_W.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 4,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   idx,
    output logic               busy,
    output logic               wrap
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [OUT_W-1:0]   out_nxt;
    logic               busy_nxt, wrap_nxt;
    logic               out_on;
    logic               scan_down, scan_down_nxt;
    logic               tmr_clr, tmr_run;
    logic               expired;
    logic               want_down;
    logic               scan_restart;
    logic               shot_end;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .dwell   (dwell),
        .expired (expired)
    );

    assign want_down = (mode == MODE_SCAN_DOWN);

    // A scan restarts at sel on load, on entry from another state, or when
    // the direction flips; scan_down remembers the direction last scanned.
    assign scan_restart = load || (state != ST_SCAN) || (want_down != scan_down);

    // Sweep finishes when the last index's dwell expires (load overrides).
    assign shot_end = (state == ST_SHOT) && expired && (&idx) && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (mode)
                MODE_DIRECT:                  state_nxt = ST_DIRECT;
                MODE_SCAN_UP, MODE_SCAN_DOWN: state_nxt = ST_SCAN;
                default: begin
                    if (load) begin
                        state_nxt = ST_SHOT;
                    end else if (state == ST_SHOT && !shot_end) begin
                        state_nxt = ST_SHOT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        idx_nxt       = idx;
        busy_nxt      = busy;
        wrap_nxt      = 1'b0;
        out_on        = 1'b0;
        scan_down_nxt = scan_down;
        tmr_clr       = 1'b0;
        tmr_run       = 1'b0;
        if (en) begin
            // Default while enabled: timer parked at zero, no sweep running.
            tmr_clr  = 1'b1;
            busy_nxt = 1'b0;
            case (mode)
                MODE_DIRECT: begin
                    idx_nxt = sel;
                    out_on  = 1'b1;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    scan_down_nxt = want_down;
                    out_on        = 1'b1;
                    if (scan_restart) begin
                        idx_nxt = sel;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_run = 1'b1;
                        if (expired) begin
                            if (want_down) begin
                                idx_nxt  = idx - SEL_W'(1);
                                wrap_nxt = (idx == '0);
                            end else begin
                                idx_nxt  = idx + SEL_W'(1);
                                wrap_nxt = &idx;
                            end
                        end
                    end
                end
                default: begin
                    if (load) begin
                        idx_nxt  = sel;
                        busy_nxt = 1'b1;
                        out_on   = 1'b1;
                    end else if (state == ST_SHOT) begin
                        tmr_clr  = 1'b0;
                        tmr_run  = 1'b1;
                        busy_nxt = 1'b1;
                        out_on   = 1'b1;
                        if (shot_end) begin
                            // idx stays on the last index; out blanks.
                            busy_nxt = 1'b0;
                            wrap_nxt = 1'b1;
                            out_on   = 1'b0;
                        end else if (expired) begin
                            idx_nxt = idx + SEL_W'(1);
                        end
                    end
                end
            endcase
        end
        out_nxt = out_on ? OUT_W'(onehot(32'(idx_nxt))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            out       <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            scan_down <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            out       <= out_nxt;
            busy      <= busy_nxt;
            wrap      <= wrap_nxt;
            scan_down <= scan_down_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;
    import decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       load;
    logic [3:0] dwell;
    logic [7:0] out;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    decoder_seq #(
        .SEL_W   (3),
        .DWELL_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .dwell (dwell),
        .out   (out),
        .idx   (idx),
        .busy  (busy),
        .wrap  (wrap)
    );

    function automatic exp_t mk(input int i, input bit on, input bit b, input bit w);
        exp_t e;
        e.idx  = 3'(i);
        e.out  = on ? (8'd1 << i) : 8'd0;
        e.busy = b;
        e.wrap = w;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; en = 1'b0; mode = MODE_DIRECT; sel = 3'd0; load = 1'b0; dwell = 4'd0;
        sb.push_back(mk(0, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
            errors++;
            $display("FAIL reset_initial: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                     out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1; sel = 3'd5;
        sb.push_back(mk(5, 1, 0, 0));
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
            errors++;
            $display("FAIL reset_driven: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                     out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
        end
        // Mid-cycle assertion: outputs must clear without a clock edge.
        rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
            errors++;
            $display("FAIL reset_async: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                     out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
        end
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        bit   en_t[5]  = '{1, 1, 1, 0, 0};
        int   sel_t[5] = '{5, 2, 5, 1, 1};
        int   idx_t[5] = '{5, 2, 5, 5, 5};
        exp_t e;
        mode = MODE_DIRECT; load = 1'b0; dwell = 4'd0;
        for (int k = 0; k < 5; k++) begin
            en = en_t[k]; sel = 3'(sel_t[k]);
            sb.push_back(mk(idx_t[k], en_t[k], 0, 0));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL direct[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
    endtask

    task automatic test_scan_up();
        int   idx_t[7] = '{6, 6, 7, 7, 0, 0, 1};
        bit   wr_t[7]  = '{0, 0, 0, 0, 1, 0, 0};
        exp_t e;
        mode = MODE_SCAN_UP; dwell = 4'd1; en = 1'b1; sel = 3'd6;
        for (int k = 0; k < 7; k++) begin
            load = (k == 0);
            sb.push_back(mk(idx_t[k], 1, 0, wr_t[k]));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL scan_up[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_scan_down();
        logic [1:0] md_t[7] = '{MODE_SCAN_DOWN, MODE_SCAN_DOWN, MODE_SCAN_DOWN, MODE_SCAN_DOWN,
                                MODE_SCAN_DOWN, MODE_SCAN_UP, MODE_SCAN_UP};
        int   sel_t[7] = '{1, 1, 1, 1, 1, 2, 2};
        int   idx_t[7] = '{1, 0, 7, 6, 5, 2, 3};
        bit   wr_t[7]  = '{0, 0, 1, 0, 0, 0, 0};
        exp_t e;
        dwell = 4'd0; en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            mode = md_t[k]; sel = 3'(sel_t[k]); load = (k == 0);
            sb.push_back(mk(idx_t[k], 1, 0, wr_t[k]));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL scan_down[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [1:0] md_t[10] = '{MODE_ONESHOT, MODE_ONESHOT, MODE_ONESHOT, MODE_ONESHOT, MODE_ONESHOT,
                                 MODE_ONESHOT, MODE_ONESHOT, MODE_ONESHOT, MODE_ONESHOT, MODE_DIRECT};
        bit   ld_t[10]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        int   sel_t[10] = '{5, 5, 5, 5, 5, 5, 5, 2, 2, 0};
        int   idx_t[10] = '{5, 6, 7, 7, 7, 5, 6, 2, 3, 0};
        bit   on_t[10]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        bit   bz_t[10]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        bit   wr_t[10]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        exp_t e;
        dwell = 4'd0; en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mode = md_t[k]; load = ld_t[k]; sel = 3'(sel_t[k]);
            sb.push_back(mk(idx_t[k], on_t[k], bz_t[k], wr_t[k]));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL oneshot[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_en_freeze();
        bit   en_t[10]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        int   idx_t[10] = '{3, 3, 3, 3, 3, 3, 3, 3, 4, 4};
        exp_t e;
        mode = MODE_SCAN_UP; dwell = 4'd3; sel = 3'd3;
        for (int k = 0; k < 10; k++) begin
            en = en_t[k]; load = (k == 0);
            sb.push_back(mk(idx_t[k], en_t[k], 0, 0));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL en_freeze[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_dwell_live();
        int   dw_t[6]  = '{5, 5, 5, 1, 1, 1};
        int   idx_t[6] = '{0, 0, 0, 1, 1, 2};
        exp_t e;
        mode = MODE_SCAN_UP; en = 1'b1; sel = 3'd0;
        for (int k = 0; k < 6; k++) begin
            dwell = 4'(dw_t[k]); load = (k == 0);
            sb.push_back(mk(idx_t[k], 1, 0, 0));
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ({out, idx, busy, wrap} !== {e.out, e.idx, e.busy, e.wrap}) begin
                errors++;
                $display("FAIL dwell_live[%0d]: got out=%b idx=%0d busy=%b wrap=%b, expected out=%b idx=%0d busy=%b wrap=%b",
                         k, out, idx, busy, wrap, e.out, e.idx, e.busy, e.wrap);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_down();
        test_oneshot();
        test_en_freeze();
        test_dwell_live();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
